ws281x_frame_src: RTL and testbench
===================================

Name: ws281x_frame_src

Overview:
- Upstream feeder for the WS281x bit-serialiser (`ws281x_drv`).
- Holds a frame of NumLeds RGB pixels written by software or bus glue.
- On a start request, applies global brightness and GRB reordering to each pixel, then streams the pixels to `ws281x_drv` through its go / valid / last / ack handshake.
- Reports busy until the driver has finished the reset latch period.

Parameters:
- NumLeds, 64, pixel buffer depth; must be >= 2.
- LedIdxW, $clog2(NumLeds), width of pixel index and count. Derived; do not override.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- wr_en_i  in  1  pixel buffer write strobe.
- wr_addr_i  in  LedIdxW  pixel index to write.
- wr_data_i  in  24  pixel as {R[23:16], G[15:8], B[7:0]}.
- num_leds_i  in  LedIdxW+1  pixels per frame; sampled on accepted start.
- brightness_i  in  8  global brightness; sampled on accepted start.
- start_i  in  1  frame request pulse.
- busy_o  out  1  frame in progress.
- drv_go_o  out  1  to driver go_i.
- drv_idle_i  in  1  from driver idle_o.
- drv_data_o  out  24  to driver data_i, GRB order, MSB sent first.
- drv_data_valid_o  out  1  to driver data_valid_i.
- drv_data_last_o  out  1  to driver data_last_i.
- drv_data_ack_i  in  1  from driver data_ack_o.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Pixel buffer contents are not reset.
  - On reset mid-frame, the block returns to IDLE next cycle. The driver must be reset in the same cycle.
- Pixel buffer:
  - NumLeds x 24 bits, one write port, one registered read port with 1-cycle latency.
  - Writes are accepted in every state.
  - Write and read to the same address in the same cycle returns old data (read-first).
  - Write with wr_addr_i >= NumLeds is ignored.
- Scaling, per channel: out = (ch * (brightness + 1)) >> 8.
  - 8x9-bit product; keep bits [15:8].
  - brightness 255 gives identity; brightness 0 gives ch >> 8, which is 0.
- Output word: drv_data_o = {G', R', B'}.
- Accepted start: start_i && state == IDLE && num_leds_i != 0 && num_leds_i <= NumLeds.
  - Otherwise start_i is ignored.
  - start_i while busy is dropped, not queued.
- State machine:
  - IDLE:
    - busy_o = 0.
    - On accepted start: latch num_leds_i as len, latch brightness_i, set idx = 0, issue read of address 0, go to LOAD.
  - LOAD (1 cycle):
    - RAM data is returned; scaling is applied.
    - drv_data_o is registered; drv_data_last_o = (idx == len - 1); drv_data_valid_o = 1.
    - Next state: KICK if idx == 0, else PRESENT.
  - KICK:
    - drv_go_o = drv_idle_i (combinational; high for exactly one cycle).
    - The driver acks in that same cycle.
    - On ack:
      - If last, clear valid and go to DRAIN.
      - Otherwise clear valid, idx++, issue read of idx, go to LOAD.
  - PRESENT:
    - Hold drv_data_o, valid and last stable until drv_data_ack_i.
    - On ack: same transitions as KICK.
  - DRAIN:
    - Wait for drv_idle_i == 1, which occurs after the driver's reset-latch wait. Then go to IDLE.
    - The cycle immediately after the final ack always sees drv_idle_i == 0; do not sample idle in that cycle.
- Latency:
  - Accepted start to drv_go_o is 2 cycles, provided the driver is idle.
  - Ack to next valid is 2 cycles. This is far below the driver's 24-bit frame time, so the driver never stalls.
- drv_data_ack_i received while drv_data_valid_o == 0 is ignored and flagged by an assertion.
- drv_go_o is never asserted outside KICK.
- Arithmetic:
  - idx and len are LedIdxW+1 bits wide; no wrap-around, since idx never exceeds len - 1.
  - Brightness and len are frozen per frame. Changing brightness_i or num_leds_i mid-frame has no effect until the next frame.
- Single-pixel frame (len == 1): last = 1 in the first LOAD; the block goes KICK -> DRAIN.

Decomposition:
- ws281x_pkg holds:
  - pixel_t struct {r, g, b}.
  - frame_state_e enum {IDLE, LOAD, KICK, PRESENT, DRAIN}.
  - Function scale_ch(ch, bright).
  - Function to_grb(pixel_t).
- One sub-module: ws281x_pixel_buf, the synchronous RAM with read-first semantics.
- FSM, counters and output register stay in ws281x_frame_src.

Test Plan:
- Write 3 pixels {FF0000, 00FF00, 0000FF}; num_leds = 3; brightness 255; start, with a bench driver model acking 24 cycles after each valid. Expected: drv_data_o = 00FF00, then FF0000, then 0000FF; last only on the third; go pulsed exactly once, 2 cycles after start.
- Brightness 127 with pixel 80FF01. Expected: output 7F4000, i.e. G' = FF*128 >> 8 = 7F, R' = 40, B' = 00. Brightness 0 gives 000000.
- num_leds = 1. Expected: single word with valid = last = 1; busy_o stays high until the model drives idle high, then drops the next cycle.
- Start with num_leds = 0, or num_leds = NumLeds + 1, or start while busy. Expected: no go, busy unchanged, no extra frame afterwards.
- During a frame, write pixel 2 before its read (visible in output) and pixel 0 after its ack (not visible). Also check the same-cycle write/read of one address returns old data.
- Assert rst_i in PRESENT. Expected: next cycle all outputs are 0 and state is IDLE; a following start produces a clean frame from pixel 0.

Source files
------------

// File: rtl/ws281x_pkg.sv
// Shared types and pixel arithmetic for the WS281x frame source.
// Pixels are stored RGB and reordered to GRB on the way to the serialiser.
package ws281x_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      KICK    = 3'd2,
      PRESENT = 3'd3,
      DRAIN   = 3'd4
   } frame_state_e;

   // (ch * (bright + 1)) >> 8, so 255 is identity and 0 blanks the channel.
   function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [7:0] bright);
      logic [16:0] w_prod;
      logic [8:0]  w_mult;
      w_mult = {1'b0, bright} + 9'd1;
      w_prod = {9'd0, ch} * {8'd0, w_mult};
      return w_prod[15:8];
   endfunction

   function automatic logic [23:0] to_grb(input pixel_t px);
      return {px.g, px.r, px.b};
   endfunction

endpackage

// File: rtl/ws281x_pixel_buf.sv
// Single-port-write, registered-read pixel RAM with read-first behaviour.
// Out-of-range write addresses are dropped.
module ws281x_pixel_buf
   import ws281x_pkg::*;
#(
   parameter int NumLeds = 64,
   parameter int LedIdxW = $clog2(NumLeds)
) (
   input  logic               clk_i,
   input  logic               wr_en_i,
   input  logic [LedIdxW-1:0] wr_addr_i,
   input  pixel_t             wr_data_i,
   input  logic               rd_en_i,
   input  logic [LedIdxW-1:0] rd_addr_i,
   output pixel_t             rd_data_o
);

   localparam logic [LedIdxW:0] Depth = (LedIdxW+1)'(NumLeds);

   pixel_t r_mem [NumLeds];
   pixel_t r_rd_data;
   logic   w_wr_ok;

   assign w_wr_ok = wr_en_i && ({1'b0, wr_addr_i} < Depth);

   // Both updates are non-blocking, so a same-address read sees the old word.
   always_ff @(posedge clk_i) begin
      if (w_wr_ok) begin
         r_mem[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         r_rd_data <= r_mem[rd_addr_i];
      end
   end

   assign rd_data_o = r_rd_data;

endmodule

// File: rtl/ws281x_frame_src.sv
// Streams a buffered frame of RGB pixels, brightness-scaled and GRB-ordered,
// into the WS281x serialiser over its go / valid / last / ack handshake.
module ws281x_frame_src
   import ws281x_pkg::*;
#(
   parameter int NumLeds = 64,
   parameter int LedIdxW = $clog2(NumLeds)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               wr_en_i,
   input  logic [LedIdxW-1:0] wr_addr_i,
   input  logic [23:0]        wr_data_i,
   input  logic [LedIdxW:0]   num_leds_i,
   input  logic [7:0]         brightness_i,
   input  logic               start_i,
   output logic               busy_o,
   output logic               drv_go_o,
   input  logic               drv_idle_i,
   output logic [23:0]        drv_data_o,
   output logic               drv_data_valid_o,
   output logic               drv_data_last_o,
   input  logic               drv_data_ack_i,
   output frame_state_e       dbg_state_o
);

   // Handshake: a word transfers on a cycle where drv_data_valid_o and
   // drv_data_ack_i are both high; data and last hold steady until then.

   localparam logic [LedIdxW:0] MaxLen = (LedIdxW+1)'(NumLeds);

   frame_state_e       r_state;
   frame_state_e       w_state_nxt;
   logic [LedIdxW:0]   r_len;
   logic [LedIdxW:0]   r_idx;
   logic [LedIdxW:0]   w_idx_nxt;
   logic [7:0]         r_bright;
   logic [23:0]        r_data;
   logic               r_valid;
   logic               r_last;
   logic               r_drain_hold;
   logic               w_start_ok;
   logic               w_ack;
   logic               w_rd_en;
   logic [LedIdxW-1:0] w_rd_addr;
   pixel_t             w_rd_px;
   pixel_t             w_scaled;

   ws281x_pixel_buf #(
      .NumLeds (NumLeds),
      .LedIdxW (LedIdxW)
   ) u_buf (
      .clk_i     (clk_i),
      .wr_en_i   (wr_en_i),
      .wr_addr_i (wr_addr_i),
      .wr_data_i (pixel_t'(wr_data_i)),
      .rd_en_i   (w_rd_en),
      .rd_addr_i (w_rd_addr),
      .rd_data_o (w_rd_px)
   );

   assign w_start_ok = start_i && (r_state == IDLE) &&
                       (num_leds_i != '0) && (num_leds_i <= MaxLen);
   assign w_ack      = r_valid && drv_data_ack_i;

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_rd_en     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_start_ok) begin
               w_state_nxt = LOAD;
               w_idx_nxt   = '0;
               w_rd_en     = 1'b1;
            end
         end
         LOAD: begin
            w_state_nxt = (r_idx == '0) ? KICK : PRESENT;
         end
         KICK, PRESENT: begin
            if (w_ack) begin
               if (r_last) begin
                  w_state_nxt = DRAIN;
               end else begin
                  w_state_nxt = LOAD;
                  w_idx_nxt   = r_idx + 1'b1;
                  w_rd_en     = 1'b1;
               end
            end
         end
         DRAIN: begin
            // The driver is still busy in the cycle after the final ack.
            if (!r_drain_hold && drv_idle_i) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_rd_addr  = w_idx_nxt[LedIdxW-1:0];
   assign w_scaled.r = scale_ch(w_rd_px.r, r_bright);
   assign w_scaled.g = scale_ch(w_rd_px.g, r_bright);
   assign w_scaled.b = scale_ch(w_rd_px.b, r_bright);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= IDLE;
         r_len        <= '0;
         r_idx        <= '0;
         r_bright     <= '0;
         r_data       <= '0;
         r_valid      <= 1'b0;
         r_last       <= 1'b0;
         r_drain_hold <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_idx        <= w_idx_nxt;
         r_drain_hold <= (w_state_nxt == DRAIN) && (r_state != DRAIN);
         if (w_start_ok) begin
            r_len    <= num_leds_i;
            r_bright <= brightness_i;
         end
         if (r_state == LOAD) begin
            r_data  <= to_grb(w_scaled);
            r_valid <= 1'b1;
            r_last  <= (r_idx == r_len - 1'b1);
         end else if (w_ack) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
         end
      end
   end

   assign busy_o           = (r_state != IDLE);
   assign drv_go_o         = (r_state == KICK) && drv_idle_i;
   assign drv_data_o       = r_data;
   assign drv_data_valid_o = r_valid;
   assign drv_data_last_o  = r_last;
   assign dbg_state_o      = r_state;

   a_ack_needs_valid: assert property (@(posedge clk_i) disable iff (rst_i)
      drv_data_ack_i |-> r_valid);
   a_go_only_in_kick: assert property (@(posedge clk_i)
      drv_go_o |-> (r_state == KICK));

endmodule

// File: tb/tb_ws281x_frame_src.sv
// Bench for ws281x_frame_src: a behavioural serialiser model acks words and
// a scoreboard of expected {last, GRB word} entries is checked on every ack.
module tb_ws281x_frame_src;
   import ws281x_pkg::*;

   localparam int NL      = 6;
   localparam int IW      = $clog2(NL);
   localparam int BIT_CYC = 24;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          wr_en_i = 1'b0;
   logic [IW-1:0] wr_addr_i = '0;
   logic [23:0]   wr_data_i = '0;
   logic [IW:0]   num_leds_i = '0;
   logic [7:0]    brightness_i = '0;
   logic          start_i = 1'b0;
   logic          busy_o;
   logic          drv_go_o;
   logic          drv_idle_i;
   logic [23:0]   drv_data_o;
   logic          drv_data_valid_o;
   logic          drv_data_last_o;
   logic          drv_data_ack_i;
   frame_state_e  dbg_state_o;

   logic          m_idle = 1'b1;
   logic          m_ack = 1'b0;
   int            m_latch = 12;

   int            n_vec = 0;
   int            n_err = 0;
   int            cyc = 0;
   int            go_cnt = 0;
   int            go_cyc = 0;
   logic [24:0]   exp_q[$];
   logic [23:0]   mirror [NL];

   assign drv_idle_i     = m_idle;
   assign drv_data_ack_i = drv_go_o | m_ack;

   ws281x_frame_src #(.NumLeds(NL)) dut (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .wr_en_i          (wr_en_i),
      .wr_addr_i        (wr_addr_i),
      .wr_data_i        (wr_data_i),
      .num_leds_i       (num_leds_i),
      .brightness_i     (brightness_i),
      .start_i          (start_i),
      .busy_o           (busy_o),
      .drv_go_o         (drv_go_o),
      .drv_idle_i       (drv_idle_i),
      .drv_data_o       (drv_data_o),
      .drv_data_valid_o (drv_data_valid_o),
      .drv_data_last_o  (drv_data_last_o),
      .drv_data_ack_i   (drv_data_ack_i),
      .dbg_state_o      (dbg_state_o)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // serialiser model and scoreboard
   initial begin
      logic        s_rst, s_fire, s_go, s_last, m_last;
      logic [23:0] s_data;
      logic [24:0] exp_w;
      int          phase, cnt;
      phase = 0; cnt = 0; m_last = 1'b0;
      forever begin
         @(negedge clk);
         s_rst  = rst_i;
         s_fire = drv_data_valid_o && drv_data_ack_i;
         s_go   = drv_go_o;
         s_last = drv_data_last_o;
         s_data = drv_data_o;
         if (s_go) begin
            go_cnt++;
            go_cyc = cyc;
         end
         if (s_fire) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL sb_word: got last=%b data=%h, required no word", s_last, s_data);
            end else begin
               exp_w = exp_q.pop_front();
               if ({s_last, s_data} !== exp_w) begin
                  n_err++;
                  $display("FAIL sb_word: got last=%b data=%h, required last=%b data=%h",
                           s_last, s_data, exp_w[24], exp_w[23:0]);
               end
            end
         end
         @(posedge clk);
         #1;
         m_ack = 1'b0;
         if (s_rst) begin
            phase  = 0;
            m_idle = 1'b1;
         end else if (s_fire) begin
            phase  = 1;
            m_idle = 1'b0;
            cnt    = BIT_CYC;
            m_last = s_last;
         end else if (phase == 1) begin
            if (cnt > 1) cnt--;
            else if (m_last) begin
               phase = 2;
               cnt   = m_latch;
            end else if (drv_data_valid_o) m_ack = 1'b1;
         end else if (phase == 2) begin
            if (cnt > 1) cnt--;
            else begin
               phase  = 0;
               m_idle = 1'b1;
            end
         end
      end
   end

   function automatic logic [23:0] model_word(input logic [23:0] rgb, input int b);
      int r, g, bl;
      r  = (int'(rgb[23:16]) * (b + 1)) / 256;
      g  = (int'(rgb[15:8])  * (b + 1)) / 256;
      bl = (int'(rgb[7:0])   * (b + 1)) / 256;
      return {g[7:0], r[7:0], bl[7:0]};
   endfunction

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_pix(input int a, input logic [23:0] d);
      wr_en_i   = 1'b1;
      wr_addr_i = a[IW-1:0];
      wr_data_i = d;
      tick();
      wr_en_i = 1'b0;
      if (a < NL) mirror[a] = d;
   endtask

   task automatic push_frame(input int n, input int b);
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), model_word(mirror[i], b)});
   endtask

   task automatic pulse_start(input int n, input int b, input bit do_wr, input int wa,
                              input logic [23:0] wd, output int sc);
      num_leds_i   = n[IW:0];
      brightness_i = b[7:0];
      wr_en_i      = do_wr;
      wr_addr_i    = wa[IW-1:0];
      wr_data_i    = wd;
      start_i      = 1'b1;
      sc           = cyc;
      tick();
      start_i = 1'b0;
      wr_en_i = 1'b0;
      if (do_wr && wa < NL) mirror[wa] = wd;
   endtask

   task automatic wait_done(input int budget, input string name);
      bit done;
      int n;
      done = 1'b0;
      for (n = 0; n < budget && !done; n++) begin
         @(negedge clk);
         if (!busy_o && exp_q.size() == 0) done = 1'b1;
      end
      n_vec++;
      if (!done) begin
         n_err++;
         $display("FAIL %s_done: busy=%b pending=%0d after %0d cycles, required idle, 0 pending",
                  name, busy_o, exp_q.size(), budget);
      end
   endtask

   task automatic wait_go(input string name);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         if (drv_go_o) seen = 1'b1;
      end
      n_vec++;
      if (!seen) begin
         n_err++;
         $display("FAIL %s_go: go=0 after 10 cycles, required go=1", name);
      end
   endtask

   // tests
   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      n_vec++;
      if ({busy_o, drv_go_o, drv_data_valid_o, drv_data_last_o, drv_data_o} !== 28'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got busy=%b go=%b valid=%b last=%b data=%h, required all 0",
                  busy_o, drv_go_o, drv_data_valid_o, drv_data_last_o, drv_data_o);
      end
      n_vec++;
      if (dbg_state_o !== IDLE) begin
         n_err++;
         $display("FAIL reset_state: got %0d, required %0d", dbg_state_o, IDLE);
      end
      rst_i = 1'b0;
      tick();
   endtask

   task automatic test_basic_order();
      int g0, sc;
      write_pix(0, 24'hFF0000);
      write_pix(1, 24'h00FF00);
      write_pix(2, 24'h0000FF);
      g0 = go_cnt;
      push_frame(3, 255);
      pulse_start(3, 255, 1'b0, 0, 24'h0, sc);
      wait_done(400, "basic");
      n_vec++;
      if (go_cnt - g0 !== 1) begin
         n_err++;
         $display("FAIL basic_go_count: got %0d, required 1", go_cnt - g0);
      end
      n_vec++;
      if (go_cyc - sc !== 2) begin
         n_err++;
         $display("FAIL basic_go_latency: got %0d cycles, required 2", go_cyc - sc);
      end
   endtask

   task automatic test_brightness();
      int sc;
      write_pix(0, 24'h80FF01);
      exp_q.push_back({1'b1, 24'h7F4000});
      pulse_start(1, 127, 1'b0, 0, 24'h0, sc);
      wait_done(200, "bright127");
      exp_q.push_back({1'b1, 24'h000000});
      pulse_start(1, 0, 1'b0, 0, 24'h0, sc);
      wait_done(200, "bright0");
      for (int k = 0; k < 3; k++) begin
         int b;
         b = $urandom_range(0, 255);
         for (int i = 0; i < 2; i++) write_pix(i, 24'($urandom));
         push_frame(2, b);
         pulse_start(2, b, 1'b0, 0, 24'h0, sc);
         wait_done(300, "bright_rand");
      end
   endtask

   task automatic test_single_busy();
      int sc;
      bit bad, rose;
      m_latch = 30;
      write_pix(0, 24'($urandom));
      push_frame(1, 200);
      pulse_start(1, 200, 1'b0, 0, 24'h0, sc);
      wait_go("single");
      bad = 1'b0;
      rose = 1'b0;
      for (int n = 0; n < 100 && !rose; n++) begin
         @(negedge clk);
         if (drv_idle_i) rose = 1'b1;
         else if (!busy_o) bad = 1'b1;
      end
      n_vec++;
      if (bad || !rose || !busy_o) begin
         n_err++;
         $display("FAIL single_busy_hold: got early_drop=%b idle_seen=%b busy=%b, required 0 1 1",
                  bad, rose, busy_o);
      end
      @(negedge clk);
      n_vec++;
      if (busy_o !== 1'b0 || dbg_state_o !== IDLE) begin
         n_err++;
         $display("FAIL single_busy_drop: got busy=%b state=%0d, required busy=0 state=%0d",
                  busy_o, dbg_state_o, IDLE);
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL single_words: got %0d pending, required 0", exp_q.size());
      end
      m_latch = 12;
   endtask

   task automatic test_bad_start();
      int g0, sc;
      g0 = go_cnt;
      pulse_start(0, 255, 1'b0, 0, 24'h0, sc);
      repeat (6) @(negedge clk);
      n_vec++;
      if (busy_o !== 1'b0 || go_cnt != g0) begin
         n_err++;
         $display("FAIL bad_len0: got busy=%b go=%0d, required busy=0 go=0", busy_o, go_cnt - g0);
      end
      pulse_start(NL + 1, 255, 1'b0, 0, 24'h0, sc);
      repeat (6) @(negedge clk);
      n_vec++;
      if (busy_o !== 1'b0 || go_cnt != g0) begin
         n_err++;
         $display("FAIL bad_len_over: got busy=%b go=%0d, required busy=0 go=0", busy_o, go_cnt - g0);
      end
      for (int i = 0; i < NL; i++) write_pix(i, 24'($urandom));
      push_frame(NL, 200);
      pulse_start(NL, 200, 1'b0, 0, 24'h0, sc);
      repeat (30) @(negedge clk);
      n_vec++;
      if (busy_o !== 1'b1) begin
         n_err++;
         $display("FAIL busy_mid_frame: got %b, required 1", busy_o);
      end
      pulse_start(2, 10, 1'b0, 0, 24'h0, sc);
      brightness_i = 8'd3;
      wait_done(600, "full_len");
      n_vec++;
      if (go_cnt - g0 !== 1) begin
         n_err++;
         $display("FAIL busy_start_go: got %0d, required 1", go_cnt - g0);
      end
      repeat (40) @(negedge clk);
      n_vec++;
      if (busy_o !== 1'b0 || go_cnt - g0 !== 1) begin
         n_err++;
         $display("FAIL no_extra_frame: got busy=%b go=%0d, required busy=0 go=1", busy_o, go_cnt - g0);
      end
   endtask

   task automatic test_midframe_write();
      int sc;
      logic [23:0] old0, n0, n2, n0b;
      write_pix(0, 24'h112233);
      write_pix(1, 24'h445566);
      write_pix(2, 24'h778899);
      old0 = mirror[0];
      n0   = 24'hA1B2C3;
      n2   = 24'hD4E5F6;
      n0b  = 24'h0F1E2D;
      exp_q.push_back({1'b0, model_word(old0, 255)});
      exp_q.push_back({1'b0, model_word(mirror[1], 255)});
      exp_q.push_back({1'b1, model_word(n2, 255)});
      pulse_start(3, 255, 1'b1, 0, n0, sc);
      wait_go("midframe");
      write_pix(2, n2);
      write_pix(0, n0b);
      wait_done(400, "midframe");
      push_frame(1, 255);
      pulse_start(1, 255, 1'b0, 0, 24'h0, sc);
      wait_done(200, "after_write");
   endtask

   task automatic test_reset_present();
      int sc;
      bit seen;
      for (int i = 0; i < 3; i++) write_pix(i, 24'($urandom));
      push_frame(3, 255);
      pulse_start(3, 255, 1'b0, 0, 24'h0, sc);
      seen = 1'b0;
      for (int n = 0; n < 100 && !seen; n++) begin
         @(negedge clk);
         if (dbg_state_o == PRESENT) seen = 1'b1;
      end
      n_vec++;
      if (!seen) begin
         n_err++;
         $display("FAIL rst_reach_present: state=%0d, required %0d", dbg_state_o, PRESENT);
      end
      tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({busy_o, drv_go_o, drv_data_valid_o, drv_data_last_o, drv_data_o} !== 28'd0 ||
          dbg_state_o !== IDLE) begin
         n_err++;
         $display("FAIL rst_mid_frame: got busy=%b go=%b valid=%b last=%b data=%h state=%0d, required 0",
                  busy_o, drv_go_o, drv_data_valid_o, drv_data_last_o, drv_data_o, dbg_state_o);
      end
      exp_q.delete();
      push_frame(3, 255);
      pulse_start(3, 255, 1'b0, 0, 24'h0, sc);
      wait_done(400, "after_reset");
   endtask

   initial begin
      test_reset();
      test_basic_order();
      test_brightness();
      test_single_busy();
      test_bad_start();
      test_midframe_write();
      test_reset_present();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
